// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg: MD sequencer state encodings and default latencies.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam int MD_MUL_LATENCY = 4;
    localparam int MD_DIV_LATENCY = 32;

endpackage

// File: rtl/hazard_controller_md_sequencer.sv
// hazard_controller_md_sequencer: MULT/DIV busy-window FSM with latency countdown.
module hazard_controller_md_sequencer
    import hazard_controller_pkg::*;
#(
    parameter int MUL_LATENCY = MD_MUL_LATENCY,
    parameter int DIV_LATENCY = MD_DIV_LATENCY,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o,
    output logic done_o
);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    // A start seen in DONE reloads immediately so back-to-back ops keep busy continuous.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q <= BUSY;
                        cnt_q   <= is_div_i ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use / branch / MULT-DIV hazard control with stall-cycle counter.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MUL_LATENCY = MD_MUL_LATENCY,
    parameter int DIV_LATENCY = MD_DIV_LATENCY,
    parameter int CNT_W       = 6,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_EX_MemRead,
    input  logic [4:0]        ID_EX_RegisterRt,
    input  logic [4:0]        IF_ID_RegisterRs,
    input  logic [4:0]        IF_ID_RegisterRt,
    input  logic              IF_ID_IsMulDiv,
    input  logic              IF_ID_ReadsHiLo,
    input  logic              ID_EX_MulDivStart,
    input  logic              ID_EX_IsDiv,
    input  logic              EX_BranchTaken,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Bubble,
    output logic              MD_Start,
    output logic              MD_Busy,
    output logic              MD_Done,
    output logic [PERF_W-1:0] StallCount
);

    logic              load_use;
    logic              md_struct;
    logic              hilo_wait;
    logic              stall;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;

    assign load_use  = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                       ((ID_EX_RegisterRt == IF_ID_RegisterRs) || (ID_EX_RegisterRt == IF_ID_RegisterRt));
    assign md_struct = IF_ID_IsMulDiv && MD_Busy && !MD_Done;
    assign hilo_wait = IF_ID_ReadsHiLo && ((MD_Busy && !MD_Done) || ID_EX_MulDivStart);
    // A taken branch squashes the ID instruction, so its stall requests are moot.
    assign stall     = !EX_BranchTaken && (load_use || md_struct || hilo_wait);

    assign PCWrite      = !stall;
    assign IF_ID_Write  = !stall;
    assign IF_ID_Flush  = EX_BranchTaken;
    assign ID_EX_Bubble = EX_BranchTaken || stall;
    assign MD_Start     = ID_EX_MulDivStart && !EX_BranchTaken;

    hazard_controller_md_sequencer #(
        .MUL_LATENCY(MUL_LATENCY),
        .DIV_LATENCY(DIV_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_sequencer (
        .clk     (clk),
        .reset   (reset),
        .start_i (MD_Start),
        .is_div_i(ID_EX_IsDiv),
        .busy_o  (MD_Busy),
        .done_o  (MD_Done)
    );

    assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: vector table, directed MD/reset/saturation sequences and random run vs a reference model.
module tb_hazard_controller;

    localparam int PW  = 8;
    localparam int SAT = (1 << PW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic mr, ismd, rhl, mds, isdiv, br;
    logic [4:0] ex_rt, rs, rt;
    logic pcw, ifw, fl, bub, st, busy, done;
    logic [PW-1:0] sc;

    int total = 0;
    int bad = 0;
    int md_left = 0;
    int scnt = 0;
    int nbusy, ndone, nstall, nstart;
    logic last_pcw, last_done;

    always #5 clk = ~clk;

    hazard_controller #(.PERF_W(PW)) dut (
        .clk              (clk),
        .reset            (reset),
        .ID_EX_MemRead    (mr),
        .ID_EX_RegisterRt (ex_rt),
        .IF_ID_RegisterRs (rs),
        .IF_ID_RegisterRt (rt),
        .IF_ID_IsMulDiv   (ismd),
        .IF_ID_ReadsHiLo  (rhl),
        .ID_EX_MulDivStart(mds),
        .ID_EX_IsDiv      (isdiv),
        .EX_BranchTaken   (br),
        .PCWrite          (pcw),
        .IF_ID_Write      (ifw),
        .IF_ID_Flush      (fl),
        .ID_EX_Bubble     (bub),
        .MD_Start         (st),
        .MD_Busy          (busy),
        .MD_Done          (done),
        .StallCount       (sc)
    );

    typedef struct {
        logic       mr;
        logic [4:0] ex_rt, rs, rt;
        logic       ismd, rhl, mds, isdiv, br;
        logic       pcw, fl, bub, st;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, a, e);
        end
    endtask

    task automatic clear();
        mr = 0; ex_rt = 0; rs = 0; rt = 0; ismd = 0; rhl = 0; mds = 0; isdiv = 0; br = 0;
    endtask

    // Reference: md_left = remaining busy cycles including the current one.
    task automatic cyc();
        bit bz, dn, lu, ms, hw, stl;
        #1;
        bz  = md_left > 0;
        dn  = md_left == 1;
        lu  = mr && ex_rt != 0 && (ex_rt == rs || ex_rt == rt);
        ms  = ismd && bz && !dn;
        hw  = rhl && ((bz && !dn) || mds);
        stl = !br && (lu || ms || hw);
        chk("PCWrite", 32'(pcw), 32'(!stl));
        chk("IF_ID_Write", 32'(ifw), 32'(!stl));
        chk("IF_ID_Flush", 32'(fl), 32'(br));
        chk("ID_EX_Bubble", 32'(bub), 32'(br || stl));
        chk("MD_Start", 32'(st), 32'(mds && !br));
        chk("MD_Busy", 32'(busy), 32'(bz));
        chk("MD_Done", 32'(done), 32'(dn));
        chk("StallCount", 32'(sc), 32'(scnt));
        nbusy += int'(busy); ndone += int'(done); nstall += int'(!pcw); nstart += int'(st);
        last_pcw = pcw; last_done = done;
        @(posedge clk);
        if (reset) begin
            md_left = 0;
            scnt = 0;
        end else begin
            if (stl && scnt < SAT) scnt++;
            if (mds && !br && md_left <= 1) md_left = isdiv ? 32 : 4;
            else if (md_left > 0) md_left--;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; clear(); cyc(); reset = 0;
        nbusy = 0; ndone = 0; nstall = 0; nstart = 0;
    endtask

    initial begin
        //            mr ert rs rt md hl st dv br | pcw fl bub st
        tbl[0]  = '{1, 8, 8, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0};
        tbl[1]  = '{1, 8, 3, 8, 0, 0, 0, 0, 0,   0, 0, 1, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0};
        tbl[3]  = '{0, 8, 8, 8, 0, 0, 0, 0, 0,   1, 0, 0, 0};
        tbl[4]  = '{1, 8, 9, 10, 0, 0, 0, 0, 0,  1, 0, 0, 0};
        tbl[5]  = '{1, 8, 8, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 1, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1,   1, 1, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0};

        reset = 1; clear();
        @(posedge clk); @(negedge clk);
        #1;
        chk("rst_StallCount", 32'(sc), 0);
        chk("rst_MD_Busy", 32'(busy), 0);
        chk("rst_MD_Done", 32'(done), 0);
        chk("rst_PCWrite", 32'(pcw), 1);
        chk("rst_IF_ID_Flush", 32'(fl), 0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            do_reset();
            mr = tbl[i].mr; ex_rt = tbl[i].ex_rt; rs = tbl[i].rs; rt = tbl[i].rt;
            ismd = tbl[i].ismd; rhl = tbl[i].rhl; mds = tbl[i].mds; isdiv = tbl[i].isdiv; br = tbl[i].br;
            #1;
            chk($sformatf("tbl%0d_PCWrite", i), 32'(pcw), 32'(tbl[i].pcw));
            chk($sformatf("tbl%0d_IF_ID_Write", i), 32'(ifw), 32'(tbl[i].pcw));
            chk($sformatf("tbl%0d_Flush", i), 32'(fl), 32'(tbl[i].fl));
            chk($sformatf("tbl%0d_Bubble", i), 32'(bub), 32'(tbl[i].bub));
            chk($sformatf("tbl%0d_MD_Start", i), 32'(st), 32'(tbl[i].st));
            cyc();
        end

        // Load-use, then $0 load.
        do_reset();
        mr = 1; ex_rt = 8; rs = 8;
        cyc();
        chk("lu_stall", 32'(last_pcw), 0);
        clear(); #1;
        chk("lu_release", 32'(pcw), 1);
        chk("lu_count", 32'(sc), 1);
        mr = 1; ex_rt = 0; rs = 0;
        cyc();
        chk("r0_nostall", 32'(last_pcw), 1);
        clear(); #1;
        chk("r0_count", 32'(sc), 1);
        cyc();

        // MULT in EX with MFLO in ID.
        do_reset();
        mds = 1; rhl = 1;
        cyc();
        mds = 0;
        for (int i = 1; i <= 4; i++) cyc();
        chk("mflo_done_cycle", 32'(last_done), 1);
        chk("mflo_proceeds", 32'(last_pcw), 1);
        rhl = 0;
        cyc();
        chk("mul_busy_cycles", 32'(nbusy), 4);
        chk("mul_done_pulses", 32'(ndone), 1);
        chk("mflo_stalls", 32'(nstall), 4);
        chk("mul_start_pulses", 32'(nstart), 1);
        #1;
        chk("mflo_count", 32'(sc), 4);

        // DIV then DIV with restart in the DONE cycle.
        do_reset();
        mds = 1; isdiv = 1;
        cyc();
        mds = 0; ismd = 1;
        for (int i = 1; i <= 31; i++) cyc();
        mds = 1;
        cyc();
        chk("div_done_cycle", 32'(last_done), 1);
        chk("div_release", 32'(last_pcw), 1);
        clear();
        for (int i = 33; i <= 65; i++) cyc();
        chk("div2_busy_cycles", 32'(nbusy), 64);
        chk("div2_done_pulses", 32'(ndone), 2);
        chk("div2_stalls", 32'(nstall), 31);

        // Reset when the DIV countdown is at 10.
        do_reset();
        mds = 1; isdiv = 1;
        cyc();
        mds = 0; ismd = 1;
        for (int i = 1; i <= 21; i++) cyc();
        reset = 1;
        cyc();
        reset = 0; clear(); ndone = 0;
        #1;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_count", 32'(sc), 0);
        for (int i = 0; i < 40; i++) cyc();
        chk("rstmid_no_done", 32'(ndone), 0);

        // Stall counter saturation.
        do_reset();
        mr = 1; ex_rt = 5; rs = 5;
        for (int i = 0; i < SAT + 20; i++) cyc();
        #1;
        chk("sat_hold", 32'(sc), 32'(SAT));
        cyc();
        #1;
        chk("sat_hold2", 32'(sc), 32'(SAT));

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            mr    = 1'($urandom_range(0, 1));
            ex_rt = 5'($urandom_range(0, 3));
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            ismd  = ($urandom_range(0, 3) == 0);
            rhl   = ($urandom_range(0, 3) == 0);
            mds   = ($urandom_range(0, 7) == 0);
            isdiv = 1'($urandom_range(0, 1));
            br    = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
